pipe_buffer: RTL

Parametrised elastic pipeline stage buffer that replaces fixed single-entry stage registers between fetch, decode, execute and memory. Carries an opaque payload (any pipeline stage struct, sized by `DATA_W`) through a DEPTH-entry circular queue with valid/ready handshakes on both sides. Supports a whole-buffer flush for branch redirects, and an optional zero-latency bypass when the buffer is empty. Sits between two pipeline stages and decouples their stalls.

---
 rtl/pipe_buffer_pkg.sv | 15 +
 rtl/pipe_buffer_mem.sv | 23 ++
 rtl/pipe_buffer.sv | 79 +++++++
 3 files changed

// File: rtl/pipe_buffer_pkg.sv
// pipe_buffer_pkg: shared operation encoding and sizing helpers for pipe_buffer.
package pipe_buffer_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buffer_mem.sv
// pipe_buffer_mem: DEPTH x DATA_W register array, one write port, one async read port, no reset.
module pipe_buffer_mem #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_buffer.sv
// pipe_buffer: elastic DEPTH-entry valid/ready stage buffer with flush.
// Define PIPE_BUFFER_BYPASS_EN for a zero-latency path when the buffer is empty.
module pipe_buffer
  import pipe_buffer_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0]  head, tail;
  logic [DATA_W-1:0] rdata;
  logic              stored, push, pop;
  op_e               op;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // in_ready ignores out_ready, so a full buffer never pushes even while popping
  assign in_ready = !flush && (count < CNT_W'(DEPTH));
  assign stored   = !flush && (count != '0);
  assign pop      = stored && out_ready;

`ifdef PIPE_BUFFER_BYPASS_EN
  logic bypass;
  assign bypass    = !reset && !flush && in_valid && (count == '0);
  assign out_valid = stored || bypass;
  assign out_data  = bypass ? in_data : rdata;
  assign push      = in_valid && in_ready && !(bypass && out_ready);
`else
  assign out_valid = stored;
  assign out_data  = rdata;
  assign push      = in_valid && in_ready;
`endif

  always_comb begin
    op = push ? (pop ? OP_BOTH : OP_PUSH) : (pop ? OP_POP : OP_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop) head <= next_ptr(head);
      count <= (op == OP_PUSH) ? count + 1'b1 : (op == OP_POP) ? count - 1'b1 : count;
    end
  end

  pipe_buffer_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(tail),
    .wdata(in_data),
    .raddr(head),
    .rdata(rdata)
  );

endmodule
